// File: rtl/iot_event_source.sv
// rtl/iot_event_source.sv - round-robin serialiser of per-device connect/disconnect events
// Optional feature macro: ACTIVE_COUNT_EN (adds active_count_o, popcount of reported-active devices)
module iot_event_source #(
    parameter int N_DEV = 8,
    parameter int PTR_W = $clog2(N_DEV)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_DEV-1:0] dev_on_i,
    input  logic             en_i,
    output logic             change_o,
    output logic             on_off_o,
    output logic [PTR_W-1:0] last_dev_o,
`ifdef ACTIVE_COUNT_EN
    output logic [7:0]       active_count_o,
`endif
    output logic             pending_o
);

    localparam logic [PTR_W:0] N_DEV_W = (PTR_W+1)'(N_DEV);
    localparam logic [PTR_W:0] LAST_W  = (PTR_W+1)'(N_DEV - 1);

    logic [N_DEV-1:0] dev_q;
    logic [N_DEV-1:0] active_map_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic             change_q;
    logic             on_off_q;
    logic [PTR_W-1:0] last_dev_q;
    logic             pending_q;
`ifdef ACTIVE_COUNT_EN
    logic [7:0]       active_count_q;
`endif

    logic [N_DEV-1:0] pend_vec;
    logic [N_DEV-1:0] grant_mask;
    logic             grant_vld;
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] rr_ptr_d;
    logic             issue;
    logic             pending_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W:0]   wrapped;
    logic [PTR_W-1:0] idx;

    // Round-robin search of unreported transitions, starting at rr_ptr and wrapping at N_DEV-1
    always_comb begin
        pend_vec  = dev_q ^ active_map_q;
        grant_vld = 1'b0;
        grant     = '0;
        sum       = '0;
        wrapped   = '0;
        idx       = '0;
        for (int k = 0; k < N_DEV; k++) begin
            sum     = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            wrapped = (sum >= N_DEV_W) ? (sum - N_DEV_W) : sum;
            idx     = wrapped[PTR_W-1:0];
            if (!grant_vld && pend_vec[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
        issue      = en_i && grant_vld;
        grant_mask = issue ? ({{(N_DEV-1){1'b0}}, 1'b1} << grant) : '0;
        pending_d  = |(pend_vec & ~grant_mask);
        rr_ptr_d   = ({1'b0, grant} == LAST_W) ? '0 : grant + 1'b1;
    end

    // Input sampling, event issue and bookkeeping of which device states have been reported
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dev_q          <= '0;
            active_map_q   <= '0;
            rr_ptr_q       <= '0;
            change_q       <= 1'b0;
            on_off_q       <= 1'b0;
            last_dev_q     <= '0;
            pending_q      <= 1'b0;
`ifdef ACTIVE_COUNT_EN
            active_count_q <= '0;
`endif
        end else begin
            dev_q     <= dev_on_i;
            pending_q <= pending_d;
            if (issue) begin
                change_q            <= 1'b1;
                on_off_q            <= dev_q[grant];
                last_dev_q          <= grant;
                active_map_q[grant] <= dev_q[grant];
                rr_ptr_q            <= rr_ptr_d;
`ifdef ACTIVE_COUNT_EN
                active_count_q      <= dev_q[grant] ? active_count_q + 8'd1
                                                    : active_count_q - 8'd1;
`endif
            end else begin
                change_q <= 1'b0;
                on_off_q <= 1'b0;
            end
        end
    end

    assign change_o   = change_q;
    assign on_off_o   = on_off_q;
    assign last_dev_o = last_dev_q;
    assign pending_o  = pending_q;
`ifdef ACTIVE_COUNT_EN
    assign active_count_o = active_count_q;
`endif

endmodule

// File: tb/tb_iot_event_source.sv
// tb/tb_iot_event_source.sv - scoreboard bench for iot_event_source with reference model
module tb_iot_event_source;

    localparam int N  = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [N-1:0]  dev_on_i;
    logic          en_i;
    logic          change_o;
    logic          on_off_o;
    logic [PW-1:0] last_dev_o;
    logic          pending_o;
`ifdef ACTIVE_COUNT_EN
    logic [7:0]    active_count_o;
`endif

    iot_event_source #(.N_DEV(N), .PTR_W(PW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .dev_on_i       (dev_on_i),
        .en_i           (en_i),
        .change_o       (change_o),
        .on_off_o       (on_off_o),
        .last_dev_o     (last_dev_o),
`ifdef ACTIVE_COUNT_EN
        .active_count_o (active_count_o),
`endif
        .pending_o      (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int chg;
        int on;
        int dev;
        int pend;
        int cnt;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_events = 0;

    // Reference state: last sampled levels, last reported level per device, search start
    int   m_dev [N];
    int   m_rep [N];
    int   m_rr;
    int   m_last;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_dev[i] = 0;
            m_rep[i] = 0;
        end
        m_rr   = 0;
        m_last = 0;
    endtask

    // Predicts the outputs after the coming rising edge, then samples the new levels
    task automatic model_step(input logic [N-1:0] din, input logic e);
        rec_t r;
        int   g;
        int   cnt;
        g = -1;
        if (e) begin
            for (int k = 0; k < N; k++) begin
                int d;
                d = (m_rr + k) % N;
                if (g < 0 && m_dev[d] != m_rep[d]) g = d;
            end
        end
        if (g >= 0) begin
            r.chg    = 1;
            r.on     = m_dev[g];
            m_rep[g] = m_dev[g];
            m_last   = g;
            m_rr     = (g + 1) % N;
        end else begin
            r.chg = 0;
            r.on  = 0;
        end
        r.dev  = m_last;
        r.pend = 0;
        cnt    = 0;
        for (int i = 0; i < N; i++) begin
            if (m_dev[i] != m_rep[i]) r.pend = 1;
            cnt += m_rep[i];
        end
        r.cnt = cnt;
        q.push_back(r);
        for (int i = 0; i < N; i++) m_dev[i] = int'(din[i]);
    endtask

    // Called at a falling edge; drives the inputs for the next rising edge
    task automatic cyc(input logic [N-1:0] din, input logic e);
        #1;
        dev_on_i = din;
        en_i     = e;
        model_step(din, e);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_change"},   int'(change_o),   0);
        chk({tag, "_on_off"},   int'(on_off_o),   0);
        chk({tag, "_last_dev"}, int'(last_dev_o), 0);
        chk({tag, "_pending"},  int'(pending_o),  0);
`ifdef ACTIVE_COUNT_EN
        chk({tag, "_count"},    int'(active_count_o), 0);
`endif
    endtask

    // Monitor: each falling edge, compare DUT outputs against the oldest prediction
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && q.size() > 0) begin
                rec_t r;
                r = q.pop_front();
                chk("change", int'(change_o), r.chg);
                chk("on_off", int'(on_off_o), r.on);
                chk("last_dev", int'(last_dev_o), r.dev);
                chk("pending", int'(pending_o), r.pend);
`ifdef ACTIVE_COUNT_EN
                chk("active_count", int'(active_count_o), r.cnt);
`endif
                if (r.chg != 0) n_events++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] cur;
        rst_i    = 1'b1;
        dev_on_i = '0;
        en_i     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_i = 1'b0;

        // Single connect, full burst, mixed off/on ordering
        cyc(4'b0100, 1);
        repeat (3) cyc(4'b0100, 1);
        cyc(4'b0000, 1);
        repeat (3) cyc(4'b0000, 1);
        cyc(4'b1111, 1);
        repeat (5) cyc(4'b1111, 1);
        cyc(4'b1010, 1);
        repeat (3) cyc(4'b1010, 1);
        cyc(4'b0101, 1);
        repeat (5) cyc(4'b0101, 1);

        // Glitch while stalled, then stalled accumulation
        cyc(4'b0000, 1);
        repeat (5) cyc(4'b0000, 1);
        cyc(4'b0010, 0);
        cyc(4'b0010, 0);
        cyc(4'b0000, 0);
        repeat (3) cyc(4'b0000, 1);
        cyc(4'b0011, 0);
        repeat (3) cyc(4'b0011, 0);
        repeat (4) cyc(4'b0011, 1);

        // Asynchronous reset in the middle of a burst
        cyc(4'b1100, 1);
        #1;
        dev_on_i = 4'b1100;
        en_i     = 1'b1;
        model_step(4'b1100, 1'b1);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        q.delete();
        model_reset();
        chk_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (6) cyc(4'b1100, 1);

        // Randomised traffic with occasional stalls
        cur = 4'b1100;
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] flip;
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 5) == 0);
            cur = cur ^ flip;
            cyc(cur, $urandom_range(0, 3) != 0);
        end
        repeat (2 * N) cyc(cur, 1);
        repeat (2) @(negedge clk);

        chk("events_seen_nonzero", int'(n_events > 20), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
